// File: rtl/addsub_sched_pkg.sv
// rtl/addsub_sched_pkg.sv - shared types and constants for the add/sub scheduler
package addsub_sched_pkg;

  // Default operand width; legal instances use 2..16.
  localparam int WIDTH_DEFAULT = 4;

  // Widest operand the result register has to carry.
  localparam int MAX_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Result register layout; sum is stored zero-extended to MAX_WIDTH.
  typedef struct packed {
    logic [MAX_WIDTH-1:0] sum;
    logic                 carry;
    logic                 ovf;
  } result_t;

  // Pick the other requester after a grant so a busy requester cannot starve its peer.
  function automatic logic next_prio(input logic granted);
    return ~granted;
  endfunction

endpackage

// File: rtl/addsub_unit.sv
// rtl/addsub_unit.sv - combinational ripple-carry adder/subtractor
module addsub_unit
  import addsub_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  // c[i] is the carry into bit i; c[0] doubles as the +1 of two's-complement subtraction.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] b_eff;

  assign b_eff = b ^ {WIDTH{sub}};
  assign c[0]  = sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b_eff[i] ^ c[i];
    assign c[i + 1] = (a[i] & b_eff[i]) | (c[i] & (a[i] ^ b_eff[i]));
  end

  // For subtraction a set carry means no borrow, i.e. a >= b unsigned.
  assign carry = c[WIDTH];
  // Signed overflow: the carry into the sign bit disagrees with the carry out of it.
  assign ovf   = c[WIDTH] ^ c[WIDTH-1];

endmodule

// File: rtl/addsub_sched.sv
// rtl/addsub_sched.sv - round-robin scheduler sharing one add/sub datapath between two requesters
module addsub_sched
  import addsub_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_sum,
  output logic             rsp0_carry,
  output logic             rsp0_ovf,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_sum,
  output logic             rsp1_carry,
  output logic             rsp1_ovf,
  output logic             busy
);

  state_t           state_q;
  state_t           state_d;
  logic             prio_q;
  logic             gnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sub_q;
  result_t          res_q;
  result_t          res_d;

  logic             accept;
  logic             gnt_c;

  logic [WIDTH-1:0] unit_sum;
  logic             unit_carry;
  logic             unit_ovf;

  addsub_unit #(
    .WIDTH(WIDTH)
  ) u_unit (
    .a    (a_q),
    .b    (b_q),
    .sub  (sub_q),
    .sum  (unit_sum),
    .carry(unit_carry),
    .ovf  (unit_ovf)
  );

  // Next-state, grant and handshake outputs; ready is held low while reset is applied.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    gnt_c      = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (!rst && (req0_valid || req1_valid)) begin
          accept     = 1'b1;
          gnt_c      = (req0_valid && req1_valid) ? prio_q : req1_valid;
          req0_ready = ~gnt_c;
          req1_ready = gnt_c;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        rsp0_valid = ~gnt_q;
        rsp1_valid = gnt_q;
        if (gnt_q ? rsp1_ready : rsp0_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the winning request's operands and rotate priority on every accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
      gnt_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
    end else if (accept) begin
      prio_q <= next_prio(gnt_c);
      gnt_q  <= gnt_c;
      a_q    <= gnt_c ? req1_a   : req0_a;
      b_q    <= gnt_c ? req1_b   : req0_b;
      sub_q  <= gnt_c ? req1_sub : req0_sub;
    end
  end

  // Pack the datapath output into the result register layout.
  always_comb begin
    res_d                = '0;
    res_d.sum[WIDTH-1:0] = unit_sum;
    res_d.carry          = unit_carry;
    res_d.ovf            = unit_ovf;
  end

  // Capture the result once, in EXEC, so it stays stable however long RESP stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
    end else if (state_q == EXEC) begin
      res_q <= res_d;
    end
  end

  // Result data goes to both ports; only the owner's valid qualifies it.
  assign rsp0_sum   = res_q.sum[WIDTH-1:0];
  assign rsp0_carry = res_q.carry;
  assign rsp0_ovf   = res_q.ovf;
  assign rsp1_sum   = res_q.sum[WIDTH-1:0];
  assign rsp1_carry = res_q.carry;
  assign rsp1_ovf   = res_q.ovf;

  // Upper result bits above WIDTH are always zero and never leave the block.
  if (WIDTH < MAX_WIDTH) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^res_q.sum[MAX_WIDTH-1:WIDTH];
  end

endmodule

// File: tb/tb_addsub_sched.sv
// tb/tb_addsub_sched.sv - scoreboard bench for addsub_sched
module tb_addsub_sched;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_sub = 1'b0, req1_sub = 1'b0;
  logic         rsp0_valid, rsp1_valid;
  logic         rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [W-1:0] rsp0_sum, rsp1_sum;
  logic         rsp0_carry, rsp1_carry, rsp0_ovf, rsp1_ovf;
  logic         busy;

  always #5 clk = ~clk;

  addsub_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_sum(rsp0_sum), .rsp0_carry(rsp0_carry), .rsp0_ovf(rsp0_ovf),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_sum(rsp1_sum), .rsp1_carry(rsp1_carry), .rsp1_ovf(rsp1_ovf),
    .busy(busy)
  );

  typedef struct {
    int sum;
    int carry;
    int ovf;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   prio_m = 0;
  int   acc_cyc[2];
  bit   lat_pend[2];
  bit   hs_prev = 1'b0;
  bit   prev_rst = 1'b1;
  bit   rand_rdy = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(int a, int b, bit sub);
    exp_t e;
    int r, sa, sb, sr;
    r       = sub ? a - b : a + b;
    e.sum   = r & ((1 << W) - 1);
    e.carry = sub ? int'(a >= b) : int'(r >= (1 << W));
    sa      = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb      = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    sr      = sub ? sa - sb : sa + sb;
    e.ovf   = int'(sr > (1 << (W - 1)) - 1 || sr < -(1 << (W - 1)));
    return e;
  endfunction

  task automatic check_rsp(int n, bit have, exp_t e, logic [W-1:0] s, logic c, logic o);
    tests++;
    if (!have) begin
      fails++;
      $display("FAIL rsp%0d_unexpected: got valid=1, expected no pending result", n);
      return;
    end
    chk($sformatf("rsp%0d_sum", n), s, e.sum);
    chk($sformatf("rsp%0d_carry", n), c, e.carry);
    chk($sformatf("rsp%0d_ovf", n), o, e.ovf);
    chk($sformatf("rsp%0d_busy", n), busy, 1);
    chk($sformatf("rsp%0d_no_req_ready", n), req0_ready | req1_ready, 0);
    if (lat_pend[n]) begin
      chk($sformatf("rsp%0d_latency", n), cyc - acc_cyc[n], 2);
      lat_pend[n] = 1'b0;
    end
  endtask

  // Monitor: model grants on accept, scoreboard results on response.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q0.delete();
      q1.delete();
      prio_m   = 0;
      lat_pend = '{1'b0, 1'b0};
      hs_prev  = 1'b0;
      chk("rst_ready", {req0_ready, req1_ready}, 0);
    end else begin
      if (prev_rst) begin
        chk("reset_idle", {busy, rsp0_valid, rsp1_valid}, 0);
        chk("reset_result", {rsp0_sum, rsp0_carry, rsp0_ovf}, 0);
      end
      if (hs_prev) chk("after_handshake", {busy, rsp0_valid, rsp1_valid}, 0);
      hs_prev = 1'b0;
      if (!busy && (req0_valid || req1_valid)) chk("idle_grant", req0_ready | req1_ready, 1);
      if (req0_ready || req1_ready) begin
        int g;
        g = (req0_valid && req1_valid) ? prio_m : (req0_valid ? 0 : 1);
        chk("one_ready", req0_ready & req1_ready, 0);
        chk("grant", req1_ready, g);
        chk("ready_idle", busy, 0);
        if (req1_ready) q1.push_back(model(req1_a, req1_b, req1_sub));
        else            q0.push_back(model(req0_a, req0_b, req0_sub));
        acc_cyc[req1_ready] = cyc;
        lat_pend[req1_ready] = 1'b1;
        prio_m = req1_ready ? 0 : 1;
      end
      if (rsp0_valid && rsp1_valid) chk("both_rsp_valid", 1, 0);
      if (rsp0_valid) begin
        check_rsp(0, q0.size() != 0, (q0.size() != 0) ? q0[0] : '{0, 0, 0}, rsp0_sum, rsp0_carry, rsp0_ovf);
        if (rsp0_ready) begin
          if (q0.size() != 0) void'(q0.pop_front());
          hs_prev = 1'b1;
        end
      end
      if (rsp1_valid) begin
        check_rsp(1, q1.size() != 0, (q1.size() != 0) ? q1[0] : '{0, 0, 0}, rsp1_sum, rsp1_carry, rsp1_ovf);
        if (rsp1_ready) begin
          if (q1.size() != 0) void'(q1.pop_front());
          hs_prev = 1'b1;
        end
      end
    end
    prev_rst = rst;
  end

  // Randomized response backpressure during the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) begin
        rsp0_ready = ($urandom_range(0, 3) != 0);
        rsp1_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Present one request (called at posedge+1) and hold it until accepted.
  task automatic issue(int n, int a, int b, bit sub);
    int t;
    bit got;
    got = 1'b0;
    if (n == 0) begin req0_a = W'(a); req0_b = W'(b); req0_sub = sub; req0_valid = 1'b1; end
    else        begin req1_a = W'(a); req1_b = W'(b); req1_sub = sub; req1_valid = 1'b1; end
    for (t = 0; t < 300 && !got; t++) begin
      @(negedge clk);
      got = (n == 0) ? req0_ready : req1_ready;
    end
    if (!got) chk($sformatf("req%0d_accept_timeout", n), 0, 1);
    @(posedge clk);
    #1;
    if (n == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    for (t = 0; t < 300 && (q0.size() != 0 || q1.size() != 0 || busy); t++) @(posedge clk);
    #1;
    chk("drain", (q0.size() == 0 && q1.size() == 0 && !busy), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic rand_stream(int n, int count);
    for (int i = 0; i < count; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      issue(n, $urandom_range(0, (1 << W) - 1), $urandom_range(0, (1 << W) - 1), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    do_reset();

    // Idle after reset.
    repeat (2) @(negedge clk);
    chk("idle_ready", {req0_ready, req1_ready}, 0);
    chk("idle_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    chk("idle_busy", busy, 0);
    @(posedge clk);
    #1;

    // Directed add/sub cases.
    issue(0, 7, 5, 1'b0);
    drain();
    issue(1, 3, 5, 1'b1);
    drain();
    issue(1, 8, 1, 1'b1);
    drain();

    // Both requesters held valid: alternating grants from prio 0.
    do_reset();
    fork
      begin issue(0, 1, 2, 1'b0); issue(0, 15, 1, 1'b0); end
      begin issue(1, 4, 9, 1'b1); issue(1, 6, 6, 1'b1); end
    join
    drain();

    // Response backpressure on requester 0 with requester 1 waiting.
    rsp0_ready = 1'b0;
    issue(0, 9, 4, 1'b0);
    fork
      issue(1, 2, 2, 1'b1);
    join_none
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rsp0_valid", rsp0_valid, 1);
      chk("stall_busy", busy, 1);
      chk("stall_req1_ready", req1_ready, 0);
    end
    @(posedge clk);
    #1;
    rsp0_ready = 1'b1;
    wait fork;
    drain();

    // Reset during EXEC discards the operation and restores prio 0.
    issue(0, 5, 6, 1'b0);
    do_reset();
    repeat (4) begin
      @(negedge clk);
      chk("post_reset_no_rsp", {rsp0_valid, rsp1_valid}, 0);
    end
    @(posedge clk);
    #1;
    fork
      issue(0, 3, 3, 1'b1);
      issue(1, 12, 7, 1'b0);
    join
    drain();

    // Random traffic with random backpressure.
    rand_rdy = 1'b1;
    fork
      rand_stream(0, 30);
      rand_stream(1, 30);
    join
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    drain();

    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
